gray_position_decoder: RTL

- Receive-side counterpart of the binary-to-Gray converter: accepts a stream of Gray-coded position samples (e.g. an absolute encoder or a Gray pointer) and decodes each to binary.
- Tracks motion between consecutive samples: step, direction, wrap-around and illegal multi-bit jumps.
- Sits between a Gray-coded source and binary consumer logic; single clock domain, registered outputs.

---
 rtl/gray_position_decoder_pkg.sv | 27 ++
 rtl/gray_position_decoder_gray_to_binary.sv | 23 ++
 rtl/gray_position_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gray_position_decoder_pkg.sv
// Shared types and helpers for the Gray-coded position decoder.
// The state enum is used by the tracker FSM. gray2bin is a width-agnostic
// helper for code that works alongside the binary-to-Gray encoder.
package gray_position_decoder_pkg;

  // Widest Gray word that the generic helper below accepts
  localparam int unsigned GRAY_MAX_W = 32;

  // Motion tracker states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } track_state_e;

  // Gray-to-binary conversion on a zero-extended word. The bits above the
  // real width are zero, so they decode to zero and leave the low bits alone.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_position_decoder_gray_to_binary.sv
// Combinational WIDTH-bit Gray-to-binary decoder. Each binary bit is the XOR
// of every Gray bit at or above its position.
module gray_to_binary #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [WIDTH-1:0] bin_d;

  // Build the result from the MSB down, carrying the running XOR
  always_comb begin
    bin_d           = '0;
    bin_d[WIDTH-1]  = gray_i[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      bin_d[i] = bin_d[i+1] ^ gray_i[i];
    end
  end

  assign bin_o = bin_d;

endmodule

// File: rtl/gray_position_decoder.sv
// Gray-coded position decoder with motion tracking.
// Stage 1 registers the raw sample together with its valid and resync flags.
// Stage 2 decodes the sample, compares it with the previous sample, and
// registers every output.
// A sample presented at edge N therefore shows out_valid after edge N+1.
// Because resync travels through stage 1 together with the sample, a resync
// that arrives with a sample is seen in the same stage-2 cycle as that sample.
module gray_position_decoder
  import gray_position_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  input  logic             resync,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             first,
  output logic             step,
  output logic             dir_up,
  output logic             wrap,
  output logic             skip_err,
  output logic             fault,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  // Stage-1 capture registers
  logic             s1_valid_q;
  logic             s1_resync_q;
  logic [WIDTH-1:0] s1_gray_q;

  // Tracker state and history
  track_state_e     state_q;
  logic [WIDTH-1:0] prev_gray_q;
  logic [WIDTH-1:0] prev_bin_q;

  // Registered outputs
  logic [WIDTH-1:0] bin_out_q;
  logic             out_valid_q;
  logic             first_q;
  logic             step_q;
  logic             dir_up_q;
  logic             wrap_q;
  logic             skip_err_q;
  logic             fault_q;
  logic [ERR_W-1:0] err_cnt_q;

  // Stage-2 combinational results
  logic [WIDTH-1:0] s1_bin;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_m1_d;
  logic             same_d;
  logic             single_d;
  logic             dir_up_d;
  logic             wrap_d;
  logic [ERR_W-1:0] err_cnt_d;

  // Register the incoming sample so that decoding and compare get a full cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_resync_q <= 1'b0;
      s1_gray_q   <= '0;
    end else begin
      s1_valid_q  <= in_valid;
      s1_resync_q <= resync;
      s1_gray_q   <= gray_in;
    end
  end

  gray_to_binary #(
    .WIDTH (WIDTH)
  ) u_gray_to_binary (
    .gray_i (s1_gray_q),
    .bin_o  (s1_bin)
  );

  // Classify the motion between the previous sample and the current one.
  // A single flipped Gray bit means the XOR is a non-zero power of two.
  always_comb begin
    diff_d    = s1_gray_q ^ prev_gray_q;
    diff_m1_d = diff_d - BIN_ONE;
    same_d    = (diff_d == '0);
    single_d  = !same_d && ((diff_d & diff_m1_d) == '0);
    dir_up_d  = (s1_bin == (prev_bin_q + BIN_ONE));
    wrap_d    = ((prev_bin_q == '1) && (s1_bin == '0)) ||
                ((prev_bin_q == '0) && (s1_bin == '1));
    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : (err_cnt_q + ERR_ONE);
  end

  // Tracker FSM. It updates the history, the state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prev_gray_q <= '0;
      prev_bin_q  <= '0;
      bin_out_q   <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      step_q      <= 1'b0;
      dir_up_q    <= 1'b0;
      wrap_q      <= 1'b0;
      skip_err_q  <= 1'b0;
      fault_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      step_q      <= 1'b0;
      dir_up_q    <= 1'b0;
      wrap_q      <= 1'b0;
      skip_err_q  <= 1'b0;

      if (s1_valid_q) begin
        prev_gray_q <= s1_gray_q;
        prev_bin_q  <= s1_bin;
        bin_out_q   <= s1_bin;
        out_valid_q <= 1'b1;
      end

      if (s1_resync_q) begin
        fault_q <= 1'b0;
        if (s1_valid_q) begin
          first_q <= 1'b1;
          state_q <= ST_TRACK;
        end else begin
          state_q <= ST_IDLE;
        end
      end else if (s1_valid_q) begin
        case (state_q)
          ST_IDLE: begin
            first_q <= 1'b1;
            state_q <= ST_TRACK;
          end
          ST_TRACK: begin
            if (single_d) begin
              step_q   <= 1'b1;
              dir_up_q <= dir_up_d;
              wrap_q   <= wrap_d;
            end else if (!same_d) begin
              skip_err_q <= 1'b1;
              err_cnt_q  <= err_cnt_d;
              fault_q    <= 1'b1;
              state_q    <= ST_FAULT;
            end
          end
          ST_FAULT: begin
            fault_q <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bin_out   = bin_out_q;
  assign out_valid = out_valid_q;
  assign first     = first_q;
  assign step      = step_q;
  assign dir_up    = dir_up_q;
  assign wrap      = wrap_q;
  assign skip_err  = skip_err_q;
  assign fault     = fault_q;
  assign err_cnt   = err_cnt_q;

endmodule
